// File: rtl/sayac_checker.sv
// Receive-side checker for a free-running counter bus: locks after a run of
// good increments, then flags broken steps and wraps. Optional macro SAYAC_CHECKER_DIR_EN adds a dir input.
module sayac_checker #(
  parameter int W          = 5,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef SAYAC_CHECKER_DIR_EN
  input  logic             dir,
`endif
  input  logic [W-1:0]     count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     expected
);

  typedef enum logic [1:0] {UNSYNC, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

  state_t           state_q, state_d;
  logic [W-1:0]     expected_q, expected_d;
  logic [3:0]       good_run_q, good_run_d;
  logic [3:0]       bad_run_q, bad_run_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;

  // Value following the current sample, and the sample value that closes a wrap.
  logic [W-1:0] next_val;
  logic         wrap_hit;
`ifdef SAYAC_CHECKER_DIR_EN
  assign next_val = dir ? (count_in - W'(1)) : (count_in + W'(1));
  assign wrap_hit = dir ? (count_in == '1) : (count_in == '0);
`else
  assign next_val = count_in + W'(1);
  assign wrap_hit = (count_in == '0);
`endif

  logic hit;
  assign hit = (count_in == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err_count_d = err_count_q;
    mismatch_d  = 1'b0;
    wrap_d      = 1'b0;

    if (en) begin
      unique case (state_q)
        UNSYNC: begin
          expected_d = next_val;
          good_run_d = '0;
          state_d    = SYNC;
        end
        SYNC: begin
          expected_d = next_val;
          if (hit) begin
            good_run_d = good_run_q + 4'd1;
            if (good_run_q + 4'd1 == LOCK_N) begin
              state_d   = LOCKED;
              bad_run_d = '0;
            end
          end else begin
            good_run_d = '0;
          end
        end
        LOCKED: begin
          // A mismatch reseeds from the observed value so one glitch costs one error.
          expected_d = next_val;
          if (hit) begin
            bad_run_d = '0;
            wrap_d    = wrap_hit;
          end else begin
            mismatch_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            if (bad_run_q + 4'd1 == UNLOCK_N) begin
              state_d    = SYNC;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
        default: state_d = UNSYNC;
      endcase
    end

    // Clear wins over history but still counts a same-cycle mismatch.
    if (clr_err) err_count_d = mismatch_d ? ERR_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      expected_q  <= '0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      err_count_q <= err_count_d;
      mismatch_q  <= mismatch_d;
      wrap_q      <= wrap_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign mismatch  = mismatch_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_sayac_checker.sv
// Directed plus randomized bench for sayac_checker against a sample-level
// reference model of the lock/mismatch/wrap rules.
module tb_sayac_checker;
  localparam int W = 5, LOCK_CNT = 4, UNLOCK_CNT = 3, ERR_W = 8;
  localparam int MODV = 1 << W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [W-1:0] count_in = '0;
  logic locked, mismatch, wrap;
  logic [ERR_W-1:0] err_count;
  logic [W-1:0] expected;
`ifdef SAYAC_CHECKER_DIR_EN
  logic dir = 1'b0;
`endif

  sayac_checker #(.W(W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef SAYAC_CHECKER_DIR_EN
    .dir(dir),
`endif
    .count_in(count_in), .clr_err(clr_err), .locked(locked), .mismatch(mismatch),
    .wrap(wrap), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  int vectors = 0, fails = 0;

  // Reference model: phase 0 = hunting, 1 = counting good steps, 2 = locked.
  int m_phase, m_exp, m_good, m_bad, m_err, m_mis, m_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_all();
    chk("locked", 32'(locked), 32'(m_phase == 2));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("expected", 32'(expected), 32'(m_exp));
  endtask

  task automatic model_reset();
    m_phase = 0; m_exp = 0; m_good = 0; m_bad = 0; m_err = 0; m_mis = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit e, input int c, input bit cl);
    bit counted = 0;
    m_mis = 0; m_wrap = 0;
    if (e) begin
      if (m_phase == 0) begin
        m_phase = 1; m_good = 0;
      end else if (m_phase == 1) begin
        if (c == m_exp) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_phase = 2; m_bad = 0; end
        end else m_good = 0;
      end else begin
        if (c == m_exp) begin
          m_bad = 0;
          m_wrap = (c == 0);
        end else begin
          m_mis = 1; counted = 1; m_bad++;
          if (m_bad == UNLOCK_CNT) begin m_phase = 1; m_good = 0; m_bad = 0; end
        end
      end
      m_exp = (c + 1) % MODV;
    end
    if (cl) m_err = counted ? 1 : 0;
    else if (counted && m_err < ERR_MAX) m_err++;
  endtask

  task automatic step(input bit e, input int c, input bit cl);
    @(negedge clk);
    rst = 1'b0; en = e; count_in = W'(c); clr_err = cl;
    model_step(e, c, cl);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset(input bit e, input int c);
    @(negedge clk);
    rst = 1'b1; en = e; count_in = W'(c); clr_err = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int wraps, e0, v;
    model_reset();
    do_reset(1'b0, 0);
    chk("rst_expected", 32'(expected), 0);

    // Acquire lock on 7..11.
    for (int i = 7; i <= 11; i++) begin
      step(1, i, 0);
      chk("lock_timing", 32'(locked), 32'(i == 11));
    end
    chk("lock_expected", 32'(expected), 12);
    chk("lock_err", 32'(err_count), 0);

    // Count up through the wrap.
    wraps = 0;
    for (int i = 12; i <= 33; i++) begin
      step(1, i % MODV, 0);
      wraps += int'(wrap);
    end
    chk("wrap_count", 32'(wraps), 1);

    // Single glitch at expected=5.
    for (int i = 2; i <= 4; i++) step(1, i, 0);
    chk("pre_glitch_exp", 32'(expected), 5);
    step(1, 9, 0);
    chk("glitch_pulse", 32'(mismatch), 1);
    chk("glitch_err", 32'(err_count), 1);
    step(1, 10, 0);
    step(1, 11, 0);
    chk("glitch_locked", 32'(locked), 1);
    chk("glitch_exp", 32'(expected), 12);

    // Three consecutive faults drop lock, then relock.
    step(1, 2, 0);  step(1, 20, 0);
    chk("fault2_locked", 32'(locked), 1);
    step(1, 7, 0);
    chk("unlock", 32'(locked), 0);
    chk("unlock_err", 32'(err_count), 4);
    for (int i = 8; i <= 11; i++) step(1, i, 0);
    chk("relock", 32'(locked), 1);

    // err_count to 5, then a mismatch together with clr_err.
    step(1, 30, 0);
    step(1, 31, 0);
    chk("err_five", 32'(err_count), 5);
    step(1, 15, 1);
    chk("clr_with_miss", 32'(err_count), 1);
    step(1, 16, 0);
    step(1, 17, 1);
    chk("clr_plain", 32'(err_count), 0);

    // Saturation: alternate a fault with a recovering match.
    for (int i = 0; i < 262; i++) begin
      v = (m_exp + 7) % MODV;
      step(1, v, 0);
      step(1, (v + 1) % MODV, 0);
    end
    chk("err_sat", 32'(err_count), ERR_MAX);
    chk("sat_locked", 32'(locked), 1);

    // en=0 freezes everything.
    e0 = m_exp;
    for (int i = 0; i < 4; i++) step(0, $urandom_range(0, MODV - 1), 0);
    chk("freeze_exp", 32'(expected), 32'(e0));
    chk("freeze_locked", 32'(locked), 1);

    // Reset while locked with en active.
    do_reset(1'b1, e0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_count), 0);
    step(0, 3, 0);
    step(1, 3, 0);

    // Randomized traffic, mostly well-behaved.
    for (int i = 0; i < 600; i++) begin
      bit e, cl;
      int c;
      e  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, MODV - 1));
      if ($urandom_range(0, 199) == 0) do_reset(e, c);
      else step(e, c, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
